// File: rtl/step_controller.sv
`default_nettype none
// ============================================================================
// Module      : step_controller
// Description : Execution-gating stage behind the clock divider. Converts the
//               divider's one-cycle slow tick into a one-cycle CPU enable
//               pulse, gated by a run switch, a single-step push-button and a
//               processor halt request. Counts issued enables for display.
//
// Ports       : clock_in   - system clock, all state on rising edge
//               reset      - asynchronous active-high reset
//               tick       - one-cycle pulse from the clock divider
//               run_sw     - free-running mode switch (asynchronous level)
//               step_btn   - single-step push-button (asynchronous level)
//               halt_in    - processor halt request (synchronous level)
//               cpu_en     - one-cycle execute-enable pulse
//               running    - high while in RUN
//               halted     - high while in HALT
//               step_count - issued cpu_en pulses, modulo 2^CNT_WIDTH
//
// Revision    : 1.0 - initial release
// ============================================================================
module step_controller #(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clock_in,
    input  logic                 reset,
    input  logic                 tick,
    input  logic                 run_sw,
    input  logic                 step_btn,
    input  logic                 halt_in,
    output logic                 cpu_en,
    output logic                 running,
    output logic                 halted,
    output logic [CNT_WIDTH-1:0] step_count
);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_RUN       = 2'd1,
        ST_STEP_WAIT = 2'd2,
        ST_HALT      = 2'd3
    } state_t;

    // Input synchronizers and step edge detection
    logic r_run_meta;
    logic r_run_s;
    logic r_step_meta;
    logic r_step_s;
    logic r_step_prev;
    logic w_step_rise;

    logic r_step_pending;

    state_t r_state;
    state_t w_state_next;
    logic   w_fire;
    logic   w_clear_pending;

    logic                 r_cpu_en;
    logic                 r_running;
    logic                 r_halted;
    logic [CNT_WIDTH-1:0] r_step_count;

    assign w_step_rise = r_step_s & ~r_step_prev;

    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) begin
            r_run_meta  <= 1'b0;
            r_run_s     <= 1'b0;
            r_step_meta <= 1'b0;
            r_step_s    <= 1'b0;
            r_step_prev <= 1'b0;
        end else begin
            r_run_meta  <= run_sw;
            r_run_s     <= r_run_meta;
            r_step_meta <= step_btn;
            r_step_s    <= r_step_meta;
            r_step_prev <= r_step_s;
        end
    end

    // Next-state and pulse decision. Priority inside each state is
    // halt_in, then run_s deassert, then tick.
    always_comb begin
        w_state_next    = r_state;
        w_fire          = 1'b0;
        // Presses seen while running or halted are thrown away.
        w_clear_pending = (r_state == ST_RUN) || (r_state == ST_HALT);
        case (r_state)
            ST_IDLE: begin
                if (halt_in) begin
                    w_state_next = ST_HALT;
                end else if (r_run_s) begin
                    w_state_next = ST_RUN;
                end else if (r_step_pending) begin
                    w_state_next = ST_STEP_WAIT;
                end
            end
            ST_RUN: begin
                if (halt_in) begin
                    w_state_next = ST_HALT;
                end else if (!r_run_s) begin
                    w_state_next = ST_IDLE;
                end else if (tick) begin
                    w_fire = 1'b1;
                end
            end
            ST_STEP_WAIT: begin
                // run_s is deliberately ignored until the step completes.
                if (halt_in) begin
                    w_state_next    = ST_HALT;
                    w_clear_pending = 1'b1;
                end else if (tick) begin
                    w_fire          = 1'b1;
                    w_clear_pending = 1'b1;
                    w_state_next    = ST_IDLE;
                end
            end
            ST_HALT: begin
                if (!r_run_s && !halt_in) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) begin
            r_state        <= ST_IDLE;
            r_step_pending <= 1'b0;
            r_cpu_en       <= 1'b0;
            r_running      <= 1'b0;
            r_halted       <= 1'b0;
            r_step_count   <= '0;
        end else begin
            r_state <= w_state_next;
            // A clear (consume or discard) takes precedence over a new press
            // arriving on the same edge.
            if (w_clear_pending) begin
                r_step_pending <= 1'b0;
            end else if (w_step_rise) begin
                r_step_pending <= 1'b1;
            end
            r_cpu_en  <= w_fire;
            // Decoded from the next state so the flags move with the state.
            r_running <= (w_state_next == ST_RUN);
            r_halted  <= (w_state_next == ST_HALT);
            if (w_fire) begin
                r_step_count <= r_step_count + CNT_WIDTH'(1);
            end
        end
    end

    assign cpu_en     = r_cpu_en;
    assign running    = r_running;
    assign halted     = r_halted;
    assign step_count = r_step_count;

endmodule
`default_nettype wire

// File: tb/tb_step_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_step_controller
// Description : Self-checking bench for step_controller. Two instances (16-bit
//               and 4-bit counters) share all stimulus. Directed scenario
//               tasks check fixed expectations; a randomized phase compares
//               every cycle against a behavioural model built from input
//               history and mode rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_step_controller;

    logic clk      = 1'b0;
    logic rst      = 1'b1;
    logic tick     = 1'b0;
    logic run_sw   = 1'b0;
    logic step_btn = 1'b0;
    logic halt_in  = 1'b0;

    logic        en16, run16, hlt16;
    logic [15:0] cnt16;
    logic        en4, run4, hlt4;
    logic [3:0]  cnt4;

    int n_checks = 0;
    int n_pass   = 0;
    int g_pulses = 0;

    step_controller #(.CNT_WIDTH(16)) u_dut16 (
        .clock_in   (clk),
        .reset      (rst),
        .tick       (tick),
        .run_sw     (run_sw),
        .step_btn   (step_btn),
        .halt_in    (halt_in),
        .cpu_en     (en16),
        .running    (run16),
        .halted     (hlt16),
        .step_count (cnt16)
    );

    step_controller #(.CNT_WIDTH(4)) u_dut4 (
        .clock_in   (clk),
        .reset      (rst),
        .tick       (tick),
        .run_sw     (run_sw),
        .step_btn   (step_btn),
        .halt_in    (halt_in),
        .cpu_en     (en4),
        .running    (run4),
        .halted     (hlt4),
        .step_count (cnt4)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural reference model ----------------
    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_STEP = 2;
    localparam int M_HALT = 3;

    int          m_mode;
    bit          m_pending;
    bit          m_en;
    int unsigned m_cnt;
    bit          rh[$];   // run_sw samples, newest first
    bit          sh[$];   // step_btn samples, newest first

    task automatic model_reset();
        m_mode    = M_IDLE;
        m_pending = 1'b0;
        m_en      = 1'b0;
        m_cnt     = 0;
        rh        = '{1'b0, 1'b0, 1'b0};
        sh        = '{1'b0, 1'b0, 1'b0};
    endtask

    // Called once per rising edge with the inputs as sampled there.
    task automatic model_edge();
        bit run_s, rise, fire, discard;
        if (rst) begin
            model_reset();
            return;
        end
        run_s   = rh[1];                 // run_sw as seen two edges ago
        rise    = sh[1] && !sh[2];       // button newly pressed, synchronized
        fire    = 1'b0;
        discard = (m_mode == M_RUN) || (m_mode == M_HALT);
        if (m_mode == M_IDLE) begin
            if (halt_in)        m_mode = M_HALT;
            else if (run_s)     m_mode = M_RUN;
            else if (m_pending) m_mode = M_STEP;
        end else if (m_mode == M_RUN) begin
            if (halt_in)        m_mode = M_HALT;
            else if (!run_s)    m_mode = M_IDLE;
            else if (tick)      fire = 1'b1;
        end else if (m_mode == M_STEP) begin
            if (halt_in) begin
                m_mode  = M_HALT;
                discard = 1'b1;
            end else if (tick) begin
                fire    = 1'b1;
                discard = 1'b1;
                m_mode  = M_IDLE;
            end
        end else begin
            if (!run_s && !halt_in) m_mode = M_IDLE;
        end
        m_pending = discard ? 1'b0 : (m_pending | rise);
        m_en      = fire;
        if (fire) m_cnt = m_cnt + 1;
        rh.push_front(run_sw);
        void'(rh.pop_back());
        sh.push_front(step_btn);
        void'(sh.pop_back());
    endtask

    // One clock: model follows the rising edge; outputs are read at the
    // falling edge, where the caller also changes inputs.
    task automatic cyc();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        if (en16) g_pulses++;
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        tick     = 1'b0;
        run_sw   = 1'b0;
        step_btn = 1'b0;
        halt_in  = 1'b0;
        cyc();
        rst      = 1'b0;
        g_pulses = 0;
    endtask

    task automatic send_tick(input int gap);
        tick = 1'b1;
        cyc();
        tick = 1'b0;
        repeat (gap) cyc();
    endtask

    // ---------------- scenario tasks ----------------
    task automatic test_reset();
        do_reset();
        n_checks++;
        if ({en16, run16, hlt16, cnt16} !== 19'd0) $display("FAIL reset_16 got=%h exp=0", {en16, run16, hlt16, cnt16});
        else n_pass++;
        n_checks++;
        if ({en4, run4, hlt4, cnt4} !== 7'd0) $display("FAIL reset_4 got=%h exp=0", {en4, run4, hlt4, cnt4});
        else n_pass++;
        send_tick(2);
        n_checks++;
        if (g_pulses !== 0 || run16 !== 1'b0) $display("FAIL idle_tick pulses=%0d running=%b exp 0/0", g_pulses, run16);
        else n_pass++;
    endtask

    task automatic test_run();
        int pulses_after_tick;
        do_reset();
        run_sw = 1'b1;
        cyc();
        cyc();
        n_checks++;
        if (run16 !== 1'b0) $display("FAIL run_early got=%b exp=0", run16);
        else n_pass++;
        cyc();
        n_checks++;
        if (run16 !== 1'b1) $display("FAIL run_third_edge got=%b exp=1", run16);
        else n_pass++;
        pulses_after_tick = 0;
        for (int k = 0; k < 5; k++) begin
            repeat (9) cyc();
            tick = 1'b1;
            cyc();
            tick = 1'b0;
            if (en16 === 1'b1) pulses_after_tick++;
            cyc();
            n_checks++;
            if (en16 !== 1'b0) $display("FAIL run_pulse_width tick=%0d got=%b exp=0", k, en16);
            else n_pass++;
        end
        n_checks++;
        if (pulses_after_tick !== 5 || g_pulses !== 5) $display("FAIL run_pulses timely=%0d total=%0d exp=5/5", pulses_after_tick, g_pulses);
        else n_pass++;
        n_checks++;
        if (cnt16 !== 16'd5 || cnt4 !== 4'd5) $display("FAIL run_count got=%0d/%0d exp=5/5", cnt16, cnt4);
        else n_pass++;
    endtask

    task automatic test_step();
        do_reset();
        step_btn = 1'b1;
        repeat (4) cyc();
        step_btn = 1'b0;
        repeat (5) cyc();
        tick = 1'b1;
        cyc();
        tick = 1'b0;
        n_checks++;
        if (en16 !== 1'b1) $display("FAIL step_first_tick got=%b exp=1", en16);
        else n_pass++;
        repeat (4) cyc();
        send_tick(4);
        send_tick(4);
        n_checks++;
        if (g_pulses !== 1 || cnt16 !== 16'd1 || cnt4 !== 4'd1) $display("FAIL step_single pulses=%0d cnt=%0d/%0d exp=1/1/1", g_pulses, cnt16, cnt4);
        else n_pass++;
        n_checks++;
        if (run16 !== 1'b0 || hlt16 !== 1'b0) $display("FAIL step_idle running=%b halted=%b exp=0/0", run16, hlt16);
        else n_pass++;
    endtask

    task automatic test_halt();
        do_reset();
        run_sw = 1'b1;
        repeat (4) cyc();
        halt_in = 1'b1;
        tick    = 1'b1;
        cyc();
        tick    = 1'b0;
        n_checks++;
        if ({en16, hlt16, run16} !== 3'b010) $display("FAIL halt_with_tick en/halted/running got=%b exp=010", {en16, hlt16, run16});
        else n_pass++;
        send_tick(3);
        send_tick(3);
        n_checks++;
        if (g_pulses !== 0 || hlt16 !== 1'b1) $display("FAIL halt_hold pulses=%0d halted=%b exp=0/1", g_pulses, hlt16);
        else n_pass++;
        halt_in = 1'b0;
        run_sw  = 1'b0;
        repeat (4) cyc();
        n_checks++;
        if (hlt16 !== 1'b0 || run16 !== 1'b0) $display("FAIL halt_exit halted=%b running=%b exp=0/0", hlt16, run16);
        else n_pass++;
    endtask

    task automatic test_discard();
        do_reset();
        run_sw = 1'b1;
        repeat (4) cyc();
        step_btn = 1'b1;
        repeat (3) cyc();
        step_btn = 1'b0;
        repeat (4) cyc();
        halt_in = 1'b1;
        repeat (2) cyc();
        step_btn = 1'b1;
        repeat (3) cyc();
        step_btn = 1'b0;
        repeat (4) cyc();
        halt_in = 1'b0;
        run_sw  = 1'b0;
        repeat (5) cyc();
        send_tick(3);
        n_checks++;
        if (g_pulses !== 0 || cnt16 !== 16'd0) $display("FAIL discard pulses=%0d cnt=%0d exp=0/0", g_pulses, cnt16);
        else n_pass++;
    endtask

    task automatic test_wrap();
        do_reset();
        run_sw = 1'b1;
        repeat (4) cyc();
        for (int i = 1; i <= 17; i++) begin
            send_tick(2);
            if (i == 15) begin
                n_checks++;
                if (cnt4 !== 4'd15) $display("FAIL wrap_15 got=%0d exp=15", cnt4);
                else n_pass++;
            end else if (i == 16) begin
                n_checks++;
                if (cnt4 !== 4'd0) $display("FAIL wrap_16 got=%0d exp=0", cnt4);
                else n_pass++;
            end else if (i == 17) begin
                n_checks++;
                if (cnt4 !== 4'd1 || cnt16 !== 16'd17) $display("FAIL wrap_17 got=%0d/%0d exp=1/17", cnt4, cnt16);
                else n_pass++;
            end
        end
        tick = 1'b1;
        cyc();
        tick = 1'b0;
        n_checks++;
        if (en16 !== 1'b1) $display("FAIL prereset_pulse got=%b exp=1", en16);
        else n_pass++;
        #1;
        rst    = 1'b1;
        run_sw = 1'b0;
        #1;
        n_checks++;
        if ({en16, en4, cnt16, cnt4} !== 22'd0) $display("FAIL async_reset got=%h exp=0", {en16, en4, cnt16, cnt4});
        else n_pass++;
        cyc();
        rst = 1'b0;
    endtask

    task automatic test_random();
        logic [22:0] exp_v;
        logic [22:0] got_v;
        int          nfail;
        nfail = 0;
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 29) == 0) run_sw   = ~run_sw;
            if ($urandom_range(0, 19) == 0) step_btn = ~step_btn;
            if ($urandom_range(0, 39) == 0) halt_in  = ~halt_in;
            tick = !tick && ($urandom_range(0, 3) == 0);
            cyc();
            exp_v = {m_en, (m_mode == M_RUN), (m_mode == M_HALT), m_cnt[15:0], m_cnt[3:0]};
            got_v = {en16, run16, hlt16, cnt16, cnt4};
            n_checks++;
            if (got_v !== exp_v || {en4, run4, hlt4} !== exp_v[22:20]) begin
                nfail++;
                if (nfail <= 20)
                    $display("FAIL random cyc=%0d got en/run/halt/cnt16/cnt4=%b/%b/%b/%0d/%0d (4b inst %b/%b/%b) exp=%b/%b/%b/%0d/%0d",
                             c, en16, run16, hlt16, cnt16, cnt4, en4, run4, hlt4,
                             exp_v[22], exp_v[21], exp_v[20], exp_v[19:4], exp_v[3:0]);
            end else begin
                n_pass++;
            end
        end
        tick    = 1'b0;
        halt_in = 1'b0;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_run();
        test_step();
        test_halt();
        test_discard();
        test_wrap();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/step_controller.md
# step_controller

Execution-gating stage that sits directly downstream of the clock divider in the processor. It consumes the divider's one-cycle slow tick and turns it into a one-cycle CPU enable pulse, under control of a run switch, a single-step push-button and a halt request from the processor. It also keeps a count of issued enables for the board display.

## Interface
- CNT_WIDTH, 16: width of the issued-enable counter.
- clock_in  in  1  system clock; all state on its rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- tick  in  1  one-cycle pulse from the clock divider, synchronous to clock_in.
- run_sw  in  1  free-running mode switch, asynchronous level.
- step_btn  in  1  single-step push-button, asynchronous level, active-high.
- halt_in  in  1  processor halt request, synchronous level.
- cpu_en  out  1  one-cycle execute-enable pulse to the processor.
- running  out  1  high while in RUN.
- halted  out  1  high while in HALT.
- step_count  out  CNT_WIDTH  number of cpu_en pulses issued, modulo 2^CNT_WIDTH.

## Operation
- run_sw and step_btn each pass through a 2-flop synchronizer, reset to 0, giving run_s and step_s.
- step_s rising edge (step_s=1, previous=0) sets step_pending. step_pending clears when consumed, or on any edge where state is RUN or HALT, so those step presses are discarded.
- States: IDLE (reset state), RUN, STEP_WAIT, HALT.
- IDLE: halt_in -> HALT. Otherwise run_s=1 -> RUN. Otherwise step_pending -> STEP_WAIT. Otherwise stay.
- RUN: halt_in -> HALT with no pulse. Otherwise run_s=0 -> IDLE with no pulse. Otherwise tick=1 -> cpu_en pulse and stay in RUN.
- STEP_WAIT: halt_in -> HALT with no pulse, clear pending. Otherwise tick=1 -> cpu_en pulse, clear step_pending, go to IDLE. run_s changes are ignored until the step completes.
- HALT: cpu_en held 0. Exit to IDLE only when run_s=0 and halt_in=0. Otherwise stay.
- Per-edge priority: reset > halt_in > run_s deassert > tick.
- step_count increments by 1 at the same edge that sets cpu_en. It wraps from all-ones to 0 with no flag.
- At most one cpu_en pulse per tick. cpu_en is never high on two consecutive cycles, because tick is one cycle wide.

## Timing
- Reset values: cpu_en=0, running=0, halted=0, step_count=0, state=IDLE, step_pending=0, synchronizers=0.
- Input latency: a run_sw or step_btn change is visible as run_s/step_s 2 edges later. step_pending sets on the 3rd edge after the button rises.
- Pulse timing: with tick=1 sampled at edge k in RUN (or STEP_WAIT), cpu_en is registered high from edge k to edge k+1. step_count shows the new value after edge k.
- running and halted are registered decodes of the state register. They change on the same edge as the state.
- halt_in sampled high at edge k while tick=1: no pulse at k, and state is HALT after k.
- Reset asserted mid-pulse clears cpu_en asynchronously, without waiting for a clock edge.

## Test plan
- Reset, then run_sw=1 held, ticks every 10 cycles for 5 ticks: running=1 from the 3rd edge, exactly 5 one-cycle cpu_en pulses each 1 edge after its tick, step_count=5.
- From IDLE, press step_btn for 4 cycles, then send 3 ticks: exactly 1 cpu_en pulse on the first tick, state returns to IDLE, step_count=1, later ticks give no pulse.
- In RUN, assert halt_in on the same cycle as a tick: no pulse, halted=1, running=0. Later ticks give no pulse. Drop halt_in and run_sw: returns to IDLE and halted=0.
- Press step_btn while in RUN and while in HALT, then return to IDLE and send a tick: no cpu_en, because both presses were discarded.
- Preload with CNT_WIDTH=4: 17 pulses in RUN wrap step_count 15 -> 0 -> 1. Assert reset mid-pulse: cpu_en and step_count drop to 0 before the next edge.
